// File: rtl/dec_forward_sb_pkg.sv
// Shared types and helpers for the decode-stage forwarding scoreboard.
package dec_fwd_pkg;

    // Src value that selects the register file.
    localparam int unsigned SRC_REG = 0;

    // rd field is sized for the widest supported register address.
    localparam int unsigned SB_RD_W = 8;

    typedef struct packed {
        logic               valid;
        logic [SB_RD_W-1:0] rd;
        logic               is_load;
    } sb_entry_t;

    function automatic int unsigned src_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dec_forward_sb_if.sv
// Decode-side bus of the forwarding unit: decoded instruction in, operand selects and stall out.
interface dec_forward_sb_if
    import dec_fwd_pkg::*;
#(
    parameter int unsigned REG_W   = 6,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned CNT_W   = 16
);
    localparam int unsigned SRC_W = src_w(DEPTH);

    logic                     DecValid;
    logic                     DecWrites;
    logic                     DecIsLoad;
    logic [REG_W-1:0]         DecRd;
    logic [NUM_SRC*REG_W-1:0] DecRs;
    logic                     Flush;
    logic                     MemBusy;
    logic [NUM_SRC*SRC_W-1:0] Src;
    logic                     Stall;
    logic [CNT_W-1:0]         StallCycles;

    modport master (
        output DecValid, DecWrites, DecIsLoad, DecRd, DecRs, Flush, MemBusy,
        input  Src, Stall, StallCycles
    );

    modport slave (
        input  DecValid, DecWrites, DecIsLoad, DecRd, DecRs, Flush, MemBusy,
        output Src, Stall, StallCycles
    );

endinterface

// File: rtl/dec_forward_sb_match.sv
// Per-source priority scan: the youngest matching producer decides between forward and hazard.
module dec_fwd_match
    import dec_fwd_pkg::*;
#(
    parameter  int unsigned REG_W      = 6,
    parameter  int unsigned DEPTH      = 3,
    parameter  int unsigned ALU_READY  = 2,
    parameter  int unsigned LOAD_READY = 3,
    localparam int unsigned SRC_W      = src_w(DEPTH)
) (
    input  sb_entry_t        sb_i [1:DEPTH],
    input  logic [REG_W-1:0] rs_i,
    output logic [SRC_W-1:0] src_o,
    output logic             hazard_o
);

    logic found_c;

    // Stage 1 is the youngest in-flight instruction, so the first hit wins.
    always_comb begin
        src_o    = SRC_W'(SRC_REG);
        hazard_o = 1'b0;
        found_c  = 1'b0;
        if (rs_i != '0) begin
            for (int unsigned k = 1; k <= DEPTH; k++) begin
                if (!found_c && sb_i[k].valid && (sb_i[k].rd == SB_RD_W'(rs_i))) begin
                    found_c = 1'b1;
                    if (k >= (sb_i[k].is_load ? LOAD_READY : ALU_READY)) begin
                        src_o = SRC_W'(k);
                    end else begin
                        hazard_o = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dec_forward_sb.sv
// Decode-stage forwarding/hazard unit: shift scoreboard of in-flight destinations,
// per-source forward selects, stall generation and a saturating stall-cycle counter.
module dec_forward_sb
    import dec_fwd_pkg::*;
#(
    parameter int unsigned REG_W      = 6,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned ALU_READY  = 2,
    parameter int unsigned LOAD_READY = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    dec_forward_sb_if.slave  bus
);

    localparam int unsigned SRC_W = src_w(DEPTH);

    if ((ALU_READY < 1) || (ALU_READY > LOAD_READY) || (LOAD_READY > DEPTH) ||
        (REG_W < 1) || (REG_W > SB_RD_W)) begin : g_bad_params
        $error("dec_forward_sb: inconsistent REG_W/ALU_READY/LOAD_READY/DEPTH");
    end

    sb_entry_t                sb_q [1:DEPTH];
    sb_entry_t                sb_d [1:DEPTH];
    logic [CNT_W-1:0]         cnt_q;
    logic [CNT_W-1:0]         cnt_d;
    logic [NUM_SRC-1:0]       hazard_c;
    logic [NUM_SRC*SRC_W-1:0] src_c;
    logic                     stall_c;
    logic                     accept_c;

    for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
        dec_fwd_match #(
            .REG_W      (REG_W),
            .DEPTH      (DEPTH),
            .ALU_READY  (ALU_READY),
            .LOAD_READY (LOAD_READY)
        ) u_match (
            .sb_i     (sb_q),
            .rs_i     (bus.DecRs[j*REG_W +: REG_W]),
            .src_o    (src_c[j*SRC_W +: SRC_W]),
            .hazard_o (hazard_c[j])
        );
    end

    // A flushed instruction never stalls and never enters the scoreboard.
    assign stall_c  = bus.DecValid & ~bus.Flush & (|hazard_c);
    assign accept_c = bus.DecValid & bus.DecWrites & (bus.DecRd != '0) & ~stall_c & ~bus.Flush;

    always_comb begin
        sb_d  = sb_q;
        cnt_d = cnt_q;
        if (!bus.MemBusy) begin
            for (int k = int'(DEPTH); k >= 2; k--) begin
                sb_d[k] = sb_q[k-1];
            end
            sb_d[1] = '0;
            if (accept_c) begin
                sb_d[1] = '{valid: 1'b1, rd: SB_RD_W'(bus.DecRd), is_load: bus.DecIsLoad};
            end
            if (stall_c && (cnt_q != '1)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int k = 1; k <= int'(DEPTH); k++) begin
                sb_q[k] <= '0;
            end
            cnt_q <= '0;
        end else begin
            sb_q  <= sb_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.Src         = src_c;
    assign bus.Stall       = stall_c;
    assign bus.StallCycles = cnt_q;

endmodule

// File: tb/tb_dec_forward_sb.sv
// Directed, table-driven bench for dec_forward_sb plus a small-counter instance for saturation.
module tb_dec_forward_sb;
    import dec_fwd_pkg::*;

    localparam int unsigned REG_W = 6;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned SAT_W = 4;
    localparam int unsigned NVEC  = 26;

    typedef struct {
        logic             rst;
        logic             valid;
        logic             writes;
        logic             is_load;
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs0;
        logic [REG_W-1:0] rs1;
        logic             flush;
        logic             busy;
        logic [1:0]       src0;
        logic [1:0]       src1;
        logic             stall;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    logic Clk = 1'b0;
    logic Reset;
    logic SatReset;
    int   n_vec = 0;
    int   n_fail = 0;
    vec_t vecs [NVEC];

    always #5 Clk = ~Clk;

    dec_forward_sb_if #(.REG_W(REG_W), .NUM_SRC(2), .DEPTH(3), .CNT_W(CNT_W)) bus ();
    dec_forward_sb_if #(.REG_W(REG_W), .NUM_SRC(2), .DEPTH(3), .CNT_W(SAT_W)) sbus ();

    dec_forward_sb #(
        .REG_W(REG_W), .NUM_SRC(2), .DEPTH(3), .ALU_READY(2), .LOAD_READY(3), .CNT_W(CNT_W)
    ) u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    dec_forward_sb #(
        .REG_W(REG_W), .NUM_SRC(2), .DEPTH(3), .ALU_READY(2), .LOAD_READY(3), .CNT_W(SAT_W)
    ) u_sat (
        .Clk   (Clk),
        .Reset (SatReset),
        .bus   (sbus)
    );

    function automatic vec_t mkv(input logic rst, input logic valid, input logic writes,
                                 input logic ld, input int rd, input int rs0, input int rs1,
                                 input logic fl, input logic bz, input int s0, input int s1,
                                 input logic st, input int cnt);
        vec_t v;
        v.rst = rst;   v.valid = valid;  v.writes = writes; v.is_load = ld;
        v.rd  = REG_W'(rd); v.rs0 = REG_W'(rs0); v.rs1 = REG_W'(rs1);
        v.flush = fl;  v.busy = bz;
        v.src0 = 2'(s0); v.src1 = 2'(s1); v.stall = st; v.cnt = CNT_W'(cnt);
        return v;
    endfunction

    task automatic check_main(input string nm, input logic [1:0] s0, input logic [1:0] s1,
                              input logic st, input logic [CNT_W-1:0] cnt);
        n_vec++;
        if ({bus.Src, bus.Stall, bus.StallCycles} !== {s1, s0, st, cnt}) begin
            n_fail++;
            $display("FAIL %s: got Src1=%0d Src0=%0d Stall=%b StallCycles=%0d, want Src1=%0d Src0=%0d Stall=%b StallCycles=%0d",
                     nm, bus.Src[3:2], bus.Src[1:0], bus.Stall, bus.StallCycles, s1, s0, st, cnt);
        end
    endtask

    task automatic check_sat(input string nm, input logic [SAT_W-1:0] cnt);
        n_vec++;
        if (sbus.StallCycles !== cnt) begin
            n_fail++;
            $display("FAIL %s: got StallCycles=%0d, want %0d", nm, sbus.StallCycles, cnt);
        end
    endtask

    initial begin
        //          rst v wr ld rd rs0 rs1 fl bz  s0 s1 st cnt
        vecs[0]  = mkv(0, 1, 1, 0, 5, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[1]  = mkv(0, 1, 1, 0, 9, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[2]  = mkv(1, 1, 0, 0, 0, 5, 9, 0, 0,  2, 0, 1, 0);
        vecs[3]  = mkv(0, 1, 0, 0, 0, 5, 9, 0, 0,  0, 0, 0, 0);
        vecs[4]  = mkv(0, 1, 1, 0, 5, 0, 0, 0, 0,  0, 0, 0, 0);
        vecs[5]  = mkv(0, 1, 1, 0, 6, 5, 0, 0, 0,  0, 0, 1, 0);
        vecs[6]  = mkv(0, 1, 1, 0, 6, 5, 0, 0, 0,  2, 0, 0, 1);
        vecs[7]  = mkv(0, 1, 1, 1, 7, 0, 0, 0, 0,  0, 0, 0, 1);
        vecs[8]  = mkv(0, 1, 0, 0, 0, 0, 7, 0, 0,  0, 0, 1, 1);
        vecs[9]  = mkv(0, 1, 0, 0, 0, 0, 7, 0, 0,  0, 0, 1, 2);
        vecs[10] = mkv(0, 1, 0, 0, 0, 0, 7, 0, 0,  0, 3, 0, 3);
        vecs[11] = mkv(0, 1, 1, 0, 3, 0, 0, 0, 0,  0, 0, 0, 3);
        vecs[12] = mkv(0, 1, 1, 0, 3, 0, 0, 0, 0,  0, 0, 0, 3);
        vecs[13] = mkv(0, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 3);
        vecs[14] = mkv(0, 1, 0, 0, 0, 3, 3, 0, 0,  2, 2, 0, 3);
        vecs[15] = mkv(0, 1, 0, 0, 0, 0, 3, 0, 0,  0, 3, 0, 3);
        vecs[16] = mkv(0, 1, 1, 1, 7, 0, 0, 0, 0,  0, 0, 0, 3);
        vecs[17] = mkv(0, 1, 0, 0, 0, 7, 0, 0, 1,  0, 0, 1, 3);
        vecs[18] = mkv(0, 1, 0, 0, 0, 7, 0, 0, 1,  0, 0, 1, 3);
        vecs[19] = mkv(0, 1, 0, 0, 0, 7, 0, 0, 1,  0, 0, 1, 3);
        vecs[20] = mkv(0, 1, 0, 0, 0, 7, 0, 0, 0,  0, 0, 1, 3);
        vecs[21] = mkv(0, 1, 0, 0, 0, 7, 0, 0, 0,  0, 0, 1, 4);
        vecs[22] = mkv(0, 1, 0, 0, 0, 7, 0, 0, 0,  3, 0, 0, 5);
        vecs[23] = mkv(0, 1, 1, 0, 5, 0, 0, 0, 0,  0, 0, 0, 5);
        vecs[24] = mkv(0, 1, 1, 0, 8, 5, 0, 1, 0,  0, 0, 0, 5);
        vecs[25] = mkv(0, 1, 0, 0, 0, 8, 5, 0, 0,  0, 2, 0, 5);

        Reset         = 1'b1;
        SatReset      = 1'b1;
        bus.DecValid  = 1'b0; bus.DecWrites = 1'b0; bus.DecIsLoad = 1'b0;
        bus.DecRd     = '0;   bus.DecRs = '0;       bus.Flush = 1'b0; bus.MemBusy = 1'b0;
        // Saturation instance sees a load r7 that also reads r7, forever.
        sbus.DecValid = 1'b1; sbus.DecWrites = 1'b1; sbus.DecIsLoad = 1'b1;
        sbus.DecRd    = REG_W'(7); sbus.DecRs = {REG_W'(0), REG_W'(7)};
        sbus.Flush    = 1'b0; sbus.MemBusy = 1'b0;

        repeat (2) @(posedge Clk);
        #1 Reset = 1'b0;
        #3 check_main("after_reset", 2'd0, 2'd0, 1'b0, '0);

        @(posedge Clk);
        #1;
        for (int i = 0; i < int'(NVEC); i++) begin
            Reset         = vecs[i].rst;
            bus.DecValid  = vecs[i].valid;
            bus.DecWrites = vecs[i].writes;
            bus.DecIsLoad = vecs[i].is_load;
            bus.DecRd     = vecs[i].rd;
            bus.DecRs     = {vecs[i].rs1, vecs[i].rs0};
            bus.Flush     = vecs[i].flush;
            bus.MemBusy   = vecs[i].busy;
            #3 check_main($sformatf("vec%0d", i), vecs[i].src0, vecs[i].src1,
                          vecs[i].stall, vecs[i].cnt);
            @(posedge Clk);
            #1;
        end
        Reset        = 1'b0;
        bus.DecValid = 1'b0;

        // Two stalls per three cycles: 2 after 3 edges, then clamp at all-ones.
        SatReset = 1'b0;
        repeat (3) @(posedge Clk);
        #1 check_sat("sat_early", SAT_W'(2));
        repeat (57) @(posedge Clk);
        #1 check_sat("sat_clamp", '1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
